// File: rtl/mem_pkg.sv
// Shared encodings for the RAM controls carried down the pipeline, plus the
// MEM-stage bus FSM state type.
package mem_pkg;

    localparam logic [1:0] MEM_WE_NONE = 2'b00;
    localparam logic [1:0] MEM_WE_SB   = 2'b01;
    localparam logic [1:0] MEM_WE_SH   = 2'b10;
    localparam logic [1:0] MEM_WE_SW   = 2'b11;

    localparam logic [2:0] MEM_RD_NONE = 3'b000;
    localparam logic [2:0] MEM_RD_LB   = 3'b001;
    localparam logic [2:0] MEM_RD_LBU  = 3'b010;
    localparam logic [2:0] MEM_RD_LH   = 3'b011;
    localparam logic [2:0] MEM_RD_LHU  = 3'b100;
    localparam logic [2:0] MEM_RD_LW   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // 110/111 are reserved encodings and behave like "no load".
    function automatic logic mem_is_load_sel(input logic [2:0] rsel);
        return (rsel >= MEM_RD_LB) && (rsel <= MEM_RD_LW);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-bus between the MEM stage (master) and memory (slave).
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     wdata;
    logic                  ack;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, addr, wstrb, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wstrb, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
// Purely combinational so the forwarding path can share it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [2:0]  rsel,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (rsel)
            MEM_RD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            MEM_RD_LBU: data = {24'd0, byte_sel};
            MEM_RD_LH:  data = {{16{half_sel[15]}}, half_sel};
            MEM_RD_LHU: data = {16'd0, half_sel};
            MEM_RD_LW:  data = rdata;
            default:    data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access: turns EX/MEM RAM controls into one req/ack bus
// transaction, stalls upstream while it is outstanding, and aligns load data.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [1:0]          in_ram_we,
    input  logic [2:0]          in_ram_rsel,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    mem_access_unit_if.master   bus,
    output logic                stall,
    output logic [DATA_W-1:0]   load_data,
    output logic                load_valid,
    output logic                misalign
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUSY = ST_BUSY;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]          state_reg;
    logic                req_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [3:0]          wstrb_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [2:0]          rsel_reg;
    logic [1:0]          addr_lo_reg;
    logic                kill_reg;
    logic [DATA_W-1:0]   load_data_reg;
    logic                load_valid_reg;
    logic                misalign_reg;

    logic                is_store;
    logic                rsel_valid;
    logic                is_load;
    logic                access;
    logic                is_half;
    logic                is_word;
    logic                misaligned;
    logic                issue;
    logic [3:0]          wstrb_next;
    logic [DATA_W-1:0]   wdata_next;
    logic [DATA_W-1:0]   aligned_rdata;

    // A store outranks a simultaneous load encoding, so the size comes from it.
    always_comb begin
        is_store   = (in_ram_we != MEM_WE_NONE);
        rsel_valid = mem_is_load_sel(in_ram_rsel);
        is_load    = ~is_store & rsel_valid;
        access     = is_store | rsel_valid;
        is_half    = is_store ? (in_ram_we == MEM_WE_SH)
                              : ((in_ram_rsel == MEM_RD_LH) || (in_ram_rsel == MEM_RD_LHU));
        is_word    = is_store ? (in_ram_we == MEM_WE_SW)
                              : (in_ram_rsel == MEM_RD_LW);
        misaligned = (is_half & in_addr[0]) | (is_word & (in_addr[1:0] != 2'b00));
        issue      = (state_reg == S_IDLE) & access & ~misaligned & ~flush;
    end

    always_comb begin
        case (in_ram_we)
            MEM_WE_SB: wstrb_next = 4'b0001 << in_addr[1:0];
            MEM_WE_SH: wstrb_next = in_addr[1] ? 4'b1100 : 4'b0011;
            MEM_WE_SW: wstrb_next = 4'b1111;
            default:   wstrb_next = 4'b0000;
        endcase
    end

    // Replicate the store operand across lanes so memory can just apply wstrb.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
            assign wdata_next[8*gi +: 8] =
                (in_ram_we == MEM_WE_SB) ? in_wdata[7:0] :
                (in_ram_we == MEM_WE_SH) ? in_wdata[8*(gi%2) +: 8] :
                (in_ram_we == MEM_WE_SW) ? in_wdata[8*gi +: 8] :
                                           8'd0;
        end
    endgenerate

    mem_load_align u_load_align (
        .rsel    (rsel_reg),
        .addr_lo (addr_lo_reg),
        .rdata   (bus.rdata),
        .data    (aligned_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            req_reg        <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wstrb_reg      <= 4'd0;
            wdata_reg      <= '0;
            rsel_reg       <= MEM_RD_NONE;
            addr_lo_reg    <= 2'd0;
            kill_reg       <= 1'b0;
            load_data_reg  <= '0;
            load_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            load_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    kill_reg <= 1'b0;
                    if (issue) begin
                        req_reg     <= 1'b1;
                        we_reg      <= is_store;
                        addr_reg    <= {in_addr[ADDR_W-1:2], 2'b00};
                        wstrb_reg   <= wstrb_next;
                        wdata_reg   <= wdata_next;
                        rsel_reg    <= is_load ? in_ram_rsel : MEM_RD_NONE;
                        addr_lo_reg <= in_addr[1:0];
                        state_reg   <= S_BUSY;
                    end else if (access & misaligned & ~flush) begin
                        misalign_reg <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        kill_reg <= 1'b1;
                    end
                    if (bus.ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= S_DONE;
                        if (rsel_reg != MEM_RD_NONE) begin
                            load_data_reg  <= aligned_rdata;
                            // A flush arriving on the ack cycle still kills the result.
                            load_valid_reg <= ~(kill_reg | flush);
                        end
                    end
                end
                S_DONE: begin
                    // Pipeline advances on this edge; the held inputs must not re-issue.
                    kill_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign stall      = rst_n & (issue | (state_reg == S_BUSY));
    assign load_data  = load_data_reg;
    assign load_valid = load_valid_reg;
    assign misalign   = misalign_reg;

    assign bus.req   = req_reg;
    assign bus.we    = we_reg;
    assign bus.addr  = addr_reg;
    assign bus.wstrb = wstrb_reg;
    assign bus.wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit against a size/offset-based
// reference model of the MEM-stage bus transaction.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  in_ram_we;
    logic [2:0]  in_ram_rsel;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_ram_we   (in_ram_we),
        .in_ram_rsel (in_ram_rsel),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .bus         (bus),
        .stall       (stall),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          txn_no = 0;
    int          req_rises = 0;
    logic        req_prev = 1'b0;
    logic [31:0] model_ld = 32'd0;

    always @(negedge clk) begin
        if (bus.req === 1'b1 && req_prev !== 1'b1) req_rises++;
        req_prev = bus.req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Access size in bytes (0 = no access); a store outranks a load.
    function automatic int size_of(input logic [1:0] we, input logic [2:0] rsel);
        if (we != 2'd0) return (we == 2'd1) ? 1 : (we == 2'd2) ? 2 : 4;
        case (rsel)
            3'd1, 3'd2: return 1;
            3'd3, 3'd4: return 2;
            3'd5:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_strb(input int sz, input logic [31:0] addr);
        int m;
        m = (1 << sz) - 1;
        return 4'(m << (addr % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] rsel, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rdata >> (8 * (addr % 4));
        case (rsel)
            3'd1: begin v = sh & 32'hFF;   return (v >= 128)   ? v + 32'hFFFF_FF00 : v; end
            3'd2: return sh & 32'hFF;
            3'd3: begin v = sh & 32'hFFFF; return (v >= 32768) ? v + 32'hFFFF_0000 : v; end
            3'd4: return sh & 32'hFFFF;
            3'd5: return rdata;
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_inputs();
        in_ram_we   = 2'd0;
        in_ram_rsel = 3'd0;
        in_addr     = 32'd0;
        in_wdata    = 32'd0;
        flush       = 1'b0;
    endtask

    // flush_at: -1 none, -2 flush while in IDLE, j >= 0 flush in BUSY cycle j.
    task automatic do_txn(input logic [1:0] we, input logic [2:0] rsel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int k, input int flush_at);
        int   sz;
        logic st;
        logic ld;
        logic mis;
        logic issue;
        logic killed;
        int   stall_cnt;
        int   rises_before;
        txn_no++;
        sz     = size_of(we, rsel);
        st     = (we != 2'd0);
        ld     = !st && sz != 0;
        mis    = (sz != 0) && (addr % sz != 0);
        issue  = (sz != 0) && !mis && (flush_at != -2);
        killed = 1'b0;
        $display("[TB] txn %0d we=%0d rsel=%0d addr=%h wdata=%h rdata=%h k=%0d flush_at=%0d",
                 txn_no, we, rsel, addr, wdata, rdata, k, flush_at);
        rises_before = req_rises;
        in_ram_we   = we;
        in_ram_rsel = rsel;
        in_addr     = addr;
        in_wdata    = wdata;
        flush       = (flush_at == -2);
        @(negedge clk);
        stall_cnt = int'(stall);
        check("stall_issue_cycle", 32'(stall), 32'(issue));
        if (!issue) begin
            @(posedge clk); #1;
            check("misalign_pulse", 32'(misalign), 32'((sz != 0) && mis && flush_at != -2));
            check("no_req", 32'(bus.req), 32'd0);
            clear_inputs();
            @(posedge clk); #1;
            check("misalign_clear", 32'(misalign), 32'd0);
            check("no_req_rise", 32'(req_rises - rises_before), 32'd0);
        end else begin
            @(posedge clk); #1;
            check("req_high", 32'(bus.req), 32'd1);
            check("bus_we", 32'(bus.we), 32'(st));
            check("bus_addr", bus.addr, addr & 32'hFFFF_FFFC);
            check("bus_wstrb", 32'(bus.wstrb), st ? 32'(exp_strb(sz, addr)) : 32'd0);
            check("bus_wdata", bus.wdata, st ? exp_wdata(sz, wdata) : 32'd0);
            for (int j = 0; j <= k; j++) begin
                bus.ack   = (j == k);
                bus.rdata = (j == k) ? rdata : $urandom;
                flush     = (j == flush_at);
                if (j == flush_at) killed = 1'b1;
                @(negedge clk);
                stall_cnt += int'(stall);
                check("req_held", 32'(bus.req), 32'd1);
                check("addr_held", bus.addr, addr & 32'hFFFF_FFFC);
                @(posedge clk); #1;
                bus.ack = 1'b0;
                flush   = 1'b0;
            end
            if (ld) model_ld = exp_load(rsel, addr, rdata);
            check("req_dropped", 32'(bus.req), 32'd0);
            check("load_valid", 32'(load_valid), 32'(ld && !killed));
            check("load_data", load_data, model_ld);
            @(negedge clk);
            stall_cnt += int'(stall);
            check("stall_cycles", 32'(stall_cnt), 32'(2 + k));
            @(posedge clk); #1;
            clear_inputs();
            check("load_valid_clear", 32'(load_valid), 32'd0);
            check("single_request", 32'(req_rises - rises_before), 32'd1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.ack   = 1'b0;
        bus.rdata = 32'd0;
        clear_inputs();
        #12;
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_addr", bus.addr, 32'd0);
        check("rst_wstrb", 32'(bus.wstrb), 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_txn(2'b00, 3'b001, 32'h0000_1003, 32'd0,          32'h80AA_5511, 0, -1);
        do_txn(2'b10, 3'b000, 32'h0000_2002, 32'h1234_BEEF, 32'd0,          3, -1);
        do_txn(2'b00, 3'b101, 32'h0000_3001, 32'd0,          32'd0,          0, -1);
        do_txn(2'b00, 3'b100, 32'h0000_3002, 32'd0,          32'h9ABC_0000, 1, -1);
        do_txn(2'b00, 3'b101, 32'h0000_3004, 32'd0,          32'hCAFE_F00D, 3,  1);
        do_txn(2'b00, 3'b011, 32'h0000_3006, 32'd0,          32'h0000_0000, 0, -2);
        do_txn(2'b11, 3'b000, 32'h0000_0010, 32'hA5A5_1234, 32'd0,          0, -1);
        do_txn(2'b00, 3'b001, 32'h0000_0011, 32'd0,          32'h0000_F200, 0, -1);

        // Reset during BUSY, then a stray ack that must be ignored.
        in_ram_rsel = 3'b101;
        in_addr     = 32'h0000_0500;
        @(posedge clk); #1;
        check("busy_before_reset", 32'(bus.req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req_drop", 32'(bus.req), 32'd0);
        check("async_stall_drop", 32'(stall), 32'd0);
        clear_inputs();
        model_ld = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.ack   = 1'b1;
        bus.rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        check("stray_ack_req", 32'(bus.req), 32'd0);
        check("stray_ack_valid", 32'(load_valid), 32'd0);
        check("stray_ack_stall", 32'(stall), 32'd0);
        check("stray_ack_data", load_data, 32'd0);
        do_txn(2'b00, 3'b101, 32'h0000_0040, 32'd0, 32'h1357_9BDF, 1, -1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  r_we;
            logic [2:0]  r_rsel;
            logic [31:0] r_addr;
            int          r_k;
            int          r_fl;
            int          pick;
            r_we   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            r_rsel = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            if ($urandom_range(0, 2) != 0) r_addr = r_addr & 32'hFFFF_FFFC | 32'($urandom_range(0, 1) * 2);
            r_k    = $urandom_range(0, 3);
            pick   = $urandom_range(0, 5);
            r_fl   = (pick == 0) ? -2 : (pick == 1) ? $urandom_range(0, r_k) : -1;
            do_txn(r_we, r_rsel, r_addr, $urandom, $urandom, r_k, r_fl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
